// File: rtl/arb_pkg.sv
// Shared arbitration types and the rotating-priority search used by the
// round-robin arbiters in this codebase.
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Widest arbiter the shared search supports (index bits / requesters).
    localparam int unsigned RR_MAX_N = 32'd8;
    localparam int unsigned RR_MAX_R = 32'd256;

    typedef struct packed {
        logic                found;
        logic [RR_MAX_N-1:0] idx;
    } rr_pick_t;

    // Scan req starting at index start, wrapping modulo 2**n; returns the
    // first set position. Bits of req at or above 2**n are ignored.
    // The loop runs from the farthest offset down to offset 0 so the last
    // hit written is the closest one to start.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_R-1:0] req,
        input logic [RR_MAX_N-1:0] start,
        input int unsigned         n
    );
        rr_pick_t            res;
        logic [RR_MAX_N-1:0] pos;
        logic [RR_MAX_N-1:0] mask;
        int unsigned         span;
        span = 32'd1 << n;
        mask = RR_MAX_N'(span - 32'd1);
        res  = '{found: 1'b0, idx: {RR_MAX_N{1'b0}}};
        for (int i = int'(RR_MAX_R) - 1; i >= 0; i--) begin
            pos = (start + RR_MAX_N'(i)) & mask;
            res = ((unsigned'(i) < span) && req[pos]) ? '{found: 1'b1, idx: pos} : res;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_dec.sv
// Parameterized N-to-2**N one-hot decoder.
module rr_grant_arbiter_dec #(
    parameter int unsigned N = 32'd3
) (
    input  logic [N-1:0]      idx,
    output logic [(2**N)-1:0] onehot
);

    // Set exactly the bit selected by idx.
    always_comb begin
        onehot      = {(2**N){1'b0}};
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: 2**N requesters share one resource. A grant is held
// until the owner releases it, drops its request, or reaches MAX_HOLD cycles;
// the next owner is then chosen starting just after the previous one.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = 32'd3,
    parameter int unsigned MAX_HOLD = 32'd16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [(2**N)-1:0]   req,
    input  logic                rel,
    output logic [(2**N)-1:0]   grant,
    output logic [N-1:0]        grant_idx,
    output logic                grant_valid
);

    localparam int unsigned R  = 32'd1 << N;
    localparam int unsigned HW = (MAX_HOLD == 32'd0) ? 32'd1 : $clog2(MAX_HOLD + 32'd1);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 32'd0) ? {HW{1'b0}} : HW'(MAX_HOLD - 32'd1);
    localparam logic [HW-1:0] CNT_SAT   = {HW{1'b1}};

    arb_state_t     state_r;
    arb_state_t     state_s;
    logic [N-1:0]   grant_idx_r;
    logic [N-1:0]   idx_s;
    logic           grant_valid_r;
    logic           valid_s;
    logic [R-1:0]   grant_r;
    logic [R-1:0]   dec_s;
    logic [N-1:0]   ptr_r;
    logic [N-1:0]   ptr_s;
    logic [HW-1:0]  hold_cnt_r;
    logic [HW-1:0]  cnt_s;
    logic [N-1:0]   start_s;
    logic           end_s;
    logic           timeout_s;
    rr_pick_t       pick_s;

    // Next-state, search and hold-counter logic.
    always_comb begin
        state_s   = state_r;
        idx_s     = grant_idx_r;
        valid_s   = grant_valid_r;
        ptr_s     = ptr_r;
        cnt_s     = hold_cnt_r;
        timeout_s = (MAX_HOLD != 32'd0) && (hold_cnt_r == HOLD_LAST);
        end_s     = rel || !req[grant_idx_r] || timeout_s;
        // While granted, the search starts just past the owner so it ranks last.
        if (state_r == ARB_GRANT) begin
            start_s = grant_idx_r + 1'b1;
        end else begin
            start_s = ptr_r;
        end
        pick_s = rr_pick(RR_MAX_R'(req), RR_MAX_N'(start_s), N);

        case (state_r)
            ARB_IDLE: begin
                if (pick_s.found) begin
                    state_s = ARB_GRANT;
                    idx_s   = N'(pick_s.idx);
                    valid_s = 1'b1;
                    cnt_s   = {HW{1'b0}};
                end else begin
                    state_s = ARB_IDLE;
                    valid_s = 1'b0;
                end
            end
            ARB_GRANT: begin
                if (end_s) begin
                    ptr_s = grant_idx_r + 1'b1;
                    cnt_s = {HW{1'b0}};
                    if (pick_s.found) begin
                        state_s = ARB_GRANT;
                        idx_s   = N'(pick_s.idx);
                        valid_s = 1'b1;
                    end else begin
                        state_s = ARB_IDLE;
                        valid_s = 1'b0;
                    end
                end else begin
                    // Saturate so an unlimited hold never wraps the counter.
                    if (hold_cnt_r != CNT_SAT) begin
                        cnt_s = hold_cnt_r + 1'b1;
                    end else begin
                        cnt_s = hold_cnt_r;
                    end
                end
            end
            default: begin
                state_s = ARB_IDLE;
                valid_s = 1'b0;
                cnt_s   = {HW{1'b0}};
            end
        endcase
    end

    rr_grant_arbiter_dec #(
        .N (N)
    ) u_grant_dec (
        .idx    (idx_s),
        .onehot (dec_s)
    );

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ARB_IDLE;
            grant_idx_r   <= {N{1'b0}};
            grant_valid_r <= 1'b0;
            grant_r       <= {R{1'b0}};
            ptr_r         <= {N{1'b0}};
            hold_cnt_r    <= {HW{1'b0}};
        end else begin
            state_r       <= state_s;
            grant_idx_r   <= idx_s;
            grant_valid_r <= valid_s;
            grant_r       <= valid_s ? dec_s : {R{1'b0}};
            ptr_r         <= ptr_s;
            hold_cnt_r    <= cnt_s;
        end
    end

    assign grant       = grant_r;
    assign grant_idx   = grant_idx_r;
    assign grant_valid = grant_valid_r;

endmodule
